// File: rtl/led_pkg.sv
// Shared encodings and board constants for the LED sequencer and its timing helpers.
package led_pkg;

    typedef enum logic [1:0] {
        MODE_ROT_L     = 2'd0,
        MODE_ROT_R     = 2'd1,
        MODE_PING_PONG = 2'd2,
        MODE_BLINK     = 2'd3
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    // One step per second on the 50 MHz board clock.
    localparam int STEP_CYCLES_DEFAULT = 50_000_000;

endpackage

// File: rtl/led_sequencer_tick_gen.sv
// Free-running prescaler: tick is high while the counter sits on its last count
// with counting enabled, so the consumer's register updates on the wrap edge.
module tick_gen
    import led_pkg::*;
#(
    parameter int STEP_CYCLES = STEP_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst_led,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = $clog2(STEP_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STEP_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             wrap_s;

    // Next count: clear wins, then wrap, then increment while enabled.
    always_comb begin
        cnt_d  = cnt_q;
        wrap_s = en && (cnt_q == CNT_MAX);
        if (clr) begin
            cnt_d = '0;
        end else if (wrap_s) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Prescaler counter register.
    always_ff @(posedge clk or negedge rst_led) begin
        if (!rst_led) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = wrap_s && !clr;

endmodule

// File: rtl/led_sequencer.sv
// Walking-LED pattern engine: four patterns over N_LED outputs, advanced by tick_gen.
module led_sequencer
    import led_pkg::*;
#(
    parameter int N_LED       = 4,
    parameter int STEP_CYCLES = STEP_CYCLES_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_led,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             mode_load,
    output logic [N_LED-1:0] led,
    output logic             step_tick,
    output logic [1:0]       mode_q
);

    logic             tick_s;
    logic [N_LED-1:0] led_q;
    logic [N_LED-1:0] led_d;
    logic             step_tick_q;
    logic             step_tick_d;
    mode_e            act_mode_q;
    mode_e            act_mode_d;
    dir_e             dir_q;
    dir_e             dir_d;
    logic             started_q;
    logic             started_d;

    tick_gen #(
        .STEP_CYCLES(STEP_CYCLES)
    ) u_tick_gen (
        .clk    (clk),
        .rst_led(rst_led),
        .en     (en),
        .clr    (mode_load),
        .tick   (tick_s)
    );

    function automatic logic [N_LED-1:0] seed_for(input mode_e m);
        logic [N_LED-1:0] s;
        case (m)
            MODE_ROT_L:     s = N_LED'(1);
            MODE_ROT_R:     s = N_LED'(1) << (N_LED - 1);
            MODE_PING_PONG: s = N_LED'(1);
            MODE_BLINK:     s = '1;
            default:        s = N_LED'(1);
        endcase
        return s;
    endfunction

    // Next-state for the pattern engine; a mode load overrides any coincident step.
    always_comb begin
        led_d       = led_q;
        act_mode_d  = act_mode_q;
        dir_d       = dir_q;
        started_d   = started_q;
        step_tick_d = tick_s;
        if (mode_load) begin
            act_mode_d  = mode_e'(mode);
            led_d       = '0;
            dir_d       = DIR_UP;
            started_d   = 1'b0;
            step_tick_d = 1'b0;
        end else if (tick_s && !started_q) begin
            led_d     = seed_for(act_mode_q);
            started_d = 1'b1;
        end else if (tick_s) begin
            case (act_mode_q)
                MODE_ROT_L: led_d = (led_q << 1) | (led_q >> (N_LED - 1));
                MODE_ROT_R: led_d = (led_q >> 1) | (led_q << (N_LED - 1));
                MODE_PING_PONG: begin
                    // A single LED cannot bounce; it simply stays lit.
                    if (N_LED == 1) begin
                        led_d = led_q;
                    end else if (dir_q == DIR_UP && led_q[N_LED-1]) begin
                        dir_d = DIR_DOWN;
                        led_d = led_q >> 1;
                    end else if (dir_q == DIR_DOWN && led_q[0]) begin
                        dir_d = DIR_UP;
                        led_d = led_q << 1;
                    end else if (dir_q == DIR_UP) begin
                        led_d = led_q << 1;
                    end else begin
                        led_d = led_q >> 1;
                    end
                end
                MODE_BLINK: led_d = ~led_q;
                default:    led_d = led_q;
            endcase
        end else begin
            led_d = led_q;
        end
    end

    // Pattern state and registered outputs.
    always_ff @(posedge clk or negedge rst_led) begin
        if (!rst_led) begin
            led_q       <= '0;
            step_tick_q <= 1'b0;
            act_mode_q  <= MODE_ROT_L;
            dir_q       <= DIR_UP;
            started_q   <= 1'b0;
        end else begin
            led_q       <= led_d;
            step_tick_q <= step_tick_d;
            act_mode_q  <= act_mode_d;
            dir_q       <= dir_d;
            started_q   <= started_d;
        end
    end

    assign led       = led_q;
    assign step_tick = step_tick_q;
    assign mode_q    = act_mode_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Bench: a 4-LED and a 1-LED sequencer share stimulus and are checked against a
// step-count model that derives each LED vector arithmetically from the step number.
module tb_led_sequencer;

    localparam int STEP0 = 4;
    localparam int STEP1 = 2;

    logic       clk;
    logic       rst_led;
    logic       en;
    logic [1:0] mode;
    logic       mode_load;
    logic [3:0] led0;
    logic       led1;
    logic       tick0;
    logic       tick1;
    logic [1:0] mode_q0;
    logic [1:0] mode_q1;

    int n_vec;
    int n_err;

    // model state: active mode and enabled cycles since the last clear
    logic [1:0] m_mode;
    int         act0;
    int         act1;
    logic       m_tick0;
    logic       m_tick1;

    led_sequencer #(.N_LED(4), .STEP_CYCLES(STEP0)) u_dut4 (
        .clk(clk), .rst_led(rst_led), .en(en), .mode(mode), .mode_load(mode_load),
        .led(led0), .step_tick(tick0), .mode_q(mode_q0)
    );

    led_sequencer #(.N_LED(1), .STEP_CYCLES(STEP1)) u_dut1 (
        .clk(clk), .rst_led(rst_led), .en(en), .mode(mode), .mode_load(mode_load),
        .led(led1), .step_tick(tick1), .mode_q(mode_q1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // LED vector after k completed steps of mode m on an n-LED strip.
    function automatic logic [31:0] exp_led(input int n, input logic [1:0] m, input int k);
        int p;
        int pos;
        logic [31:0] mask;
        mask = (32'd1 << n) - 32'd1;
        if (k == 0) return 32'd0;
        case (m)
            2'd0: return 32'd1 << ((k - 1) % n);
            2'd1: return 32'd1 << (n - 1 - ((k - 1) % n));
            2'd2: begin
                if (n == 1) return 32'd1;
                p   = (k - 1) % (2 * n - 2);
                pos = (p < n) ? p : (2 * n - 2 - p);
                return 32'd1 << pos;
            end
            default: return (k % 2 == 1) ? mask : 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_mode  = 2'd0;
        act0    = 0;
        act1    = 0;
        m_tick0 = 1'b0;
        m_tick1 = 1'b0;
    endtask

    task automatic model_step();
        if (mode_load) begin
            m_mode  = mode;
            act0    = 0;
            act1    = 0;
            m_tick0 = 1'b0;
            m_tick1 = 1'b0;
        end else if (en) begin
            act0++;
            act1++;
            m_tick0 = (act0 % STEP0 == 0);
            m_tick1 = (act1 % STEP1 == 0);
        end else begin
            m_tick0 = 1'b0;
            m_tick1 = 1'b0;
        end
    endtask

    task automatic compare_all();
        check_val("led4",  32'(led0),    exp_led(4, m_mode, act0 / STEP0));
        check_val("tick4", 32'(tick0),   32'(m_tick0));
        check_val("mode4", 32'(mode_q0), 32'(m_mode));
        check_val("led1",  32'(led1),    exp_led(1, m_mode, act1 / STEP1));
        check_val("tick1", 32'(tick1),   32'(m_tick1));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic async_reset();
        #2;
        rst_led = 1'b0;
        #1;
        model_reset();
        check_val("rst_led4", 32'(led0), 32'd0);
        check_val("rst_mode", 32'(mode_q0), 32'd0);
        check_val("rst_tick", 32'(tick0), 32'd0);
        @(negedge clk);
        rst_led = 1'b1;
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst_led   = 1'b0;
        en        = 1'b0;
        mode      = 2'd0;
        mode_load = 1'b0;
        model_reset();
        #3;
        compare_all();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_led = 1'b1;

        // ROT_L from reset
        en = 1'b1;
        repeat (3) cycle();
        check_val("rotl_hold", 32'(led0), 32'd0);
        cycle();
        check_val("rotl_first", 32'(led0), 32'h1);
        repeat (20) cycle();

        // PING_PONG load and bounce
        mode      = 2'd2;
        mode_load = 1'b1;
        cycle();
        mode_load = 1'b0;
        check_val("pp_clear", 32'(led0), 32'd0);
        repeat (36) cycle();

        // ROT_L pause mid-step
        mode      = 2'd0;
        mode_load = 1'b1;
        cycle();
        mode_load = 1'b0;
        repeat (10) cycle();
        en = 1'b0;
        repeat (10) cycle();
        en = 1'b1;
        repeat (12) cycle();

        // ROT_R
        mode      = 2'd1;
        mode_load = 1'b1;
        cycle();
        mode_load = 1'b0;
        repeat (22) cycle();

        // BLINK load landing on a step edge
        for (int g = 0; g < 8 && (act0 % STEP0) != (STEP0 - 1); g++) cycle();
        mode      = 2'd3;
        mode_load = 1'b1;
        cycle();
        mode_load = 1'b0;
        check_val("blink_collide_led", 32'(led0), 32'd0);
        check_val("blink_collide_mode", 32'(mode_q0), 32'd3);
        repeat (14) cycle();

        // async reset mid-sequence, then restart timing
        async_reset();
        repeat (12) cycle();

        // randomized run
        for (int i = 0; i < 3000; i++) begin
            en        = ($urandom_range(0, 9) != 0);
            mode      = 2'($urandom_range(0, 3));
            mode_load = ($urandom_range(0, 39) == 0);
            if (en && (act0 % STEP0) == (STEP0 - 1) && $urandom_range(0, 3) == 0) mode_load = 1'b1;
            cycle();
            if (i == 1500) begin
                en        = 1'b1;
                mode_load = 1'b0;
                async_reset();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/led_sequencer.md
Name: led_sequencer

Overview:
- Parametrised successor to the fixed 4-LED, 1 s-per-step walking-LED block.
- Drives N_LED board LEDs with a programmable step period and four display patterns.
- Supports run/pause control and a mode register loaded at run time.
- Sits directly behind the board pins. A free-running prescaler produces a step tick, and a pattern engine advances the LED vector on each tick.

Parameters:
- N_LED, 4, number of LED outputs; legal range 1..32.
- STEP_CYCLES, 50_000_000, clk cycles per pattern step (1 s at 50 MHz); must be >= 2.
- CNT_W, $clog2(STEP_CYCLES), prescaler counter width; derived, never overridden.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_led  input  1  asynchronous, active-low reset.
- en  input  1  run enable. 1 = prescaler counts and pattern advances; 0 = counter and LEDs hold.
- mode  input  2  requested pattern: 0 ROT_L, 1 ROT_R, 2 PING_PONG, 3 BLINK.
- mode_load  input  1  single-cycle strobe; captures mode and restarts the sequence.
- led  output  N_LED  LED drive, 1 = on.
- step_tick  output  1  one-cycle pulse marking each pattern step (debug/chaining).
- mode_q  output  2  currently active mode.

Behaviour:
- Reset (rst_led low, asynchronous) clears all state:
  - cnt=0, led=0, step_tick=0, mode_q=0 (ROT_L), dir=up, started=0.
- Prescaler:
  - While en=1, cnt increments each clk.
  - When cnt reaches STEP_CYCLES-1, cnt wraps to 0 and step_tick=1 for that one cycle (registered, so step_tick is high in the cycle after cnt==STEP_CYCLES-1).
  - While en=0, cnt holds and step_tick=0.
- First step after reset or after a mode load (started=0): led is loaded with the seed for mode_q, then started=1. Seeds:
  - ROT_L and PING_PONG: 0..01
  - ROT_R: 10..0
  - BLINK: all ones
- Later steps (started=1):
  - ROT_L: rotate left by one; MSB wraps to LSB.
  - ROT_R: rotate right by one; LSB wraps to MSB.
  - PING_PONG: shift toward MSB while dir=up. When led[N_LED-1]=1 at a step, dir flips to down and led shifts right. Symmetric at LSB: when led[0]=1 with dir=down, dir flips to up and led shifts left. No end LED is repeated.
  - BLINK: led <= ~led.
- N_LED=1: every non-BLINK mode holds led=1 after the first step. BLINK toggles normally.
- mode_load=1 in a cycle:
  - mode_q<=mode, cnt<=0, led<=0, started<=0, dir<=up, step_tick<=0.
  - Takes priority over a coincident tick; that step is discarded.
  - Acts regardless of en.
- led only changes on step_tick-qualified cycles or mode_load; no glitch paths. All outputs are registered.
- Latency:
  - From reset release with en=1, the first led change happens STEP_CYCLES cycles later, then every STEP_CYCLES cycles.
  - A pause of k cycles stretches the current step by exactly k cycles.
- Reset asserted mid-step clears everything immediately. The sequence restarts from the seed after a full STEP_CYCLES.

Decomposition:
- Package led_pkg:
  - mode encodings MODE_ROT_L=2'd0, MODE_ROT_R=2'd1, MODE_PING_PONG=2'd2, MODE_BLINK=2'd3
  - default STEP_CYCLES constant for the 50 MHz board clock
- Sub-module tick_gen (parameters STEP_CYCLES; ports clk, rst_led, en, clr, tick):
  - holds the prescaler and is reused by later timing blocks
- led_sequencer instantiates tick_gen and contains the pattern engine.

Test Plan:
- Reset and ROT_L (N_LED=4, STEP_CYCLES=4, en=1, no load):
  - led=0000 for the first 4 cycles, then 0001, 0010, 0100, 1000, 0001, changing every 4 cycles.
  - step_tick high exactly 1 cycle per step.
- PING_PONG load (mode=2, one-cycle mode_load):
  - led=0000, then per step 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010.
  - mode_q=2.
- Pause: en=0 for 10 cycles mid-step while led=0010 (ROT_L):
  - led and cnt frozen.
  - The next change (0100) arrives 10 cycles later than unpaused.
  - No step_tick while en=0.
- BLINK plus load/tick collision: assert mode_load (mode=3) in the same cycle as step_tick:
  - led=0000, mode_q=3, and no step taken that cycle.
  - Then 1111, 0000, 1111 every 4 cycles.
- ROT_R:
  - seed 1000, then 0100, 0010, 0001, 1000.
- Async reset mid-sequence: drop rst_led between clk edges while led=0100:
  - led=0000 and mode_q=0 immediately, without waiting for a clock edge.
  - After release, 0001 appears after exactly 4 cycles.
